// File: rtl/temp_bcd_if.sv
// Handshake/result bundle between a temperature source and temp_bcd_converter.
// master: drives start/temp_bin, sees busy/done/digits/overflow. slave: the converter.
interface temp_bcd_if #(
  parameter int IN_WIDTH = 10
);
  logic                start;
  logic [IN_WIDTH-1:0] temp_bin;
  logic                busy;
  logic                done;
  logic [3:0]          temp_value_100;
  logic [3:0]          temp_value_10;
  logic [3:0]          temp_value_1;
  logic                overflow;

  modport master (
    output start,
    output temp_bin,
    input  busy,
    input  done,
    input  temp_value_100,
    input  temp_value_10,
    input  temp_value_1,
    input  overflow
  );

  modport slave (
    input  start,
    input  temp_bin,
    output busy,
    output done,
    output temp_value_100,
    output temp_value_10,
    output temp_value_1,
    output overflow
  );
endinterface

// File: rtl/temp_bcd_converter.sv
// Iterative binary-to-BCD converter (double dabble) for the temperature readout.
// Ports: clk, reset (sync, active-high), bus (temp_bcd_if.slave: start, temp_bin,
//   busy, done, temp_value_100/10/1, overflow). Macro TEMP_BCD_CLAMP_EN clamps
//   overflowed samples to 999; otherwise digits show temp_bin mod 1000.
module temp_bcd_converter #(
  parameter int IN_WIDTH = 10
) (
  input logic       clk,
  input logic       reset,
  temp_bcd_if.slave bus
);
  localparam int CW = $clog2(IN_WIDTH);
  localparam logic [IN_WIDTH-1:0] MAX_DEC = IN_WIDTH'(999);
  localparam logic [CW-1:0] CNT_INIT = CW'(IN_WIDTH - 1);

  if (IN_WIDTH < 10 || IN_WIDTH > 14) begin : g_bad_width
    $error("temp_bcd_converter: IN_WIDTH must be 10..14");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [11:0]         r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;
  logic [3:0]          r_d100;
  logic [3:0]          r_d10;
  logic [3:0]          r_d1;
  logic                r_overflow;

  logic [11:0] w_adj;
  logic [11:0] w_bcd_nxt;
  logic        w_unused_carry;
  logic [11:0] w_res;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_adj = {add3(r_bcd[11:8]),
                  add3(r_bcd[7:4]),
                  add3(r_bcd[3:0])};

  // The bit leaving the hundreds nibble is dropped: result is mod 1000.
  assign {w_unused_carry, w_bcd_nxt} =
    {w_adj, r_bin[IN_WIDTH-1]};

`ifdef TEMP_BCD_CLAMP_EN
  assign w_res = r_ovf ? 12'h999 : r_bcd;
`else
  assign w_res = r_bcd;
`endif

  // busy stays high through the cycle that shows done, so the
  // next sample is accepted one edge after the result appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_d100     <= 4'd0;
      r_d10      <= 4'd0;
      r_d1       <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_bin   <= bus.temp_bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_INIT;
            r_ovf   <= (bus.temp_bin > MAX_DEC);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_d100     <= w_res[11:8];
          r_d10      <= w_res[7:4];
          r_d1       <= w_res[3:0];
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.temp_value_100 = r_d100;
  assign bus.temp_value_10  = r_d10;
  assign bus.temp_value_1   = r_d1;
  assign bus.overflow       = r_overflow;

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Scoreboard bench for temp_bcd_converter: random and directed samples,
// decimal reference model, latency/busy/hold checks in a separate monitor.
module tb_temp_bcd_converter;
  localparam int W = 10;
  localparam int LAT = W + 1;
  localparam int SPACING = W + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  temp_bcd_if #(.IN_WIDTH(W)) bus ();

  temp_bcd_converter #(.IN_WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h;
    int t;
    int o;
    int ov;
    int at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int acc_prev = -100;
  int acc_cur = -100;
  int free_edge = 0;
  int last_h = 0, last_t = 0, last_o = 0, last_ov = 0;

  function automatic exp_t model(input int v, input int e);
    exp_t x;
    int m;
    m = v % 1000;
    x.h = m / 100;
    x.t = (m / 10) % 10;
    x.o = m % 10;
    x.ov = (v > 999) ? 1 : 0;
`ifdef TEMP_BCD_CLAMP_EN
    if (x.ov == 1) begin
      x.h = 9;
      x.t = 9;
      x.o = 9;
    end
`endif
    x.at = e + LAT;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int in_win(input int a);
    return (cyc >= a && cyc <= a + LAT) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", int'(bus.busy),
          (in_win(acc_prev) | in_win(acc_cur)));
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("done_cycle", cyc, x.at);
          chk("d100", int'(bus.temp_value_100), x.h);
          chk("d10", int'(bus.temp_value_10), x.t);
          chk("d1", int'(bus.temp_value_1), x.o);
          chk("overflow", int'(bus.overflow), x.ov);
          last_h = x.h;
          last_t = x.t;
          last_o = x.o;
          last_ov = x.ov;
        end
      end else begin
        chk("hold", {int'(bus.temp_value_100), int'(bus.temp_value_10),
                     int'(bus.temp_value_1), int'(bus.overflow)} != 0 ?
            int'({bus.temp_value_100, bus.temp_value_10,
                  bus.temp_value_1, bus.overflow}) :
            0,
            (last_h << 9) | (last_t << 5) | (last_o << 1) | last_ov);
      end
    end
  end

  task automatic step(input logic s, input int v);
    int e;
    bus.start = s;
    bus.temp_bin = v[W-1:0];
    e = cyc + 1;
    if (s && e >= free_edge) begin
      q.push_back(model(v, e));
      acc_prev = acc_cur;
      acc_cur = e;
      free_edge = e + SPACING;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    reset = 1'b1;
    q.delete();
    acc_prev = -100;
    acc_cur = -100;
    free_edge = 0;
    last_h = 0;
    last_t = 0;
    last_o = 0;
    last_ov = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.temp_bin = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    step(1'b1, 0);
    idle(12);
    step(1'b1, 75);
    idle(12);
    step(1'b1, 999);
    idle(12);
    step(1'b1, 1023);
    idle(12);

    step(1'b1, 128);
    idle(2);
    step(1'b1, 456);
    idle(8);
    step(1'b1, 456);
    idle(12);

    step(1'b1, 250);
    idle(12);
    step(1'b1, 731);
    idle(4);
    do_reset();
    idle(15);

    for (int i = 0; i < 1024; i++) step(1'b1, i);
    idle(12);

    repeat (400) begin
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 1023)));
    end
    idle(12);

    for (int k = 0; k < 20 && q.size() != 0; k++) idle(1);
    if (q.size() != 0) chk("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
